// File: rtl/rv32i_types.sv
// rv32i_types: shared types and constants for the LSQ data-memory path
package rv32i_types;
    localparam int LSQ_DEPTH = 8;
    localparam int PHYS_WIDTH = 6;
    localparam int ROB_IDX_WIDTH = 5;
    localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010, LBU = 3'b100, LHU = 3'b101;
    typedef enum logic [1:0] {IDLE, LD_WAIT, ST_WAIT, LD_DROP} lsq_arb_state_t;
    // funct3[1:0] encodes access size for both signed and unsigned loads
    function automatic logic [3:0] load_rmask(input logic [2:0] funct3, input logic [1:0] off);
        return funct3[1:0] == 2'b00 ? 4'b0001 << off : funct3[1:0] == 2'b01 ? 4'b0011 << off : 4'b1111;
    endfunction
endpackage

// File: rtl/load_align.sv
// load_align: shifts cache read data down to the accessed bytes and extends per funct3
module load_align
    import rv32i_types::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  off,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);
    logic [31:0] sh;
    always_comb begin
        sh = rdata >> {off, 3'b000};
        data = funct3 == LB  ? {{24{sh[7]}}, sh[7:0]} :
               funct3 == LBU ? {24'b0, sh[7:0]} :
               funct3 == LH  ? {{16{sh[15]}}, sh[15:0]} :
               funct3 == LHU ? {16'b0, sh[15:0]} : sh;
    end
endmodule

// File: rtl/lsq_dmem_arbiter.sv
// lsq_dmem_arbiter: sequences the single data-cache port between LQ issue and SQ commit head
module lsq_dmem_arbiter
    import rv32i_types::*;
#(
    parameter int DEPTH = LSQ_DEPTH,
    parameter int STARVE_LIMIT = 4,
    localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     br_flush,
    input  logic                     lq_empty,
    input  logic                     ld_valid,
    input  logic [31:0]              ld_addr,
    input  logic [2:0]               ld_funct3,
    input  logic [PHYS_WIDTH-1:0]    ld_rd_paddr,
    input  logic [ROB_IDX_WIDTH-1:0] ld_rob_idx,
    input  logic                     st_valid,
    input  logic [ADDR_WIDTH-1:0]    st_index,
    input  logic [31:0]              st_addr,
    input  logic [3:0]               st_wmask,
    input  logic [31:0]              st_wdata,
    output logic                     lq_stall,
    output logic                     store_selected,
    output logic [ADDR_WIDTH-1:0]    store_selected_index,
    output logic [31:0]              dmem_addr,
    output logic [3:0]               dmem_rmask,
    output logic [3:0]               dmem_wmask,
    output logic [31:0]              dmem_wdata,
    input  logic                     dmem_resp,
    input  logic [31:0]              dmem_rdata,
    output logic                     ld_wb_valid,
    output logic [PHYS_WIDTH-1:0]    ld_wb_paddr,
    output logic [31:0]              ld_wb_data,
    output logic [ROB_IDX_WIDTH-1:0] ld_wb_rob_idx,
    output logic                     st_done
);
    localparam int CW = $clog2(STARVE_LIMIT) + 1;
    lsq_arb_state_t state, state_next;
    logic [31:0] req_addr, req_wdata, aligned;
    logic [2:0] req_funct3;
    logic [3:0] req_wmask;
    logic [PHYS_WIDTH-1:0] req_paddr;
    logic [ROB_IDX_WIDTH-1:0] req_rob_idx;
    logic [CW-1:0] starve_cnt;
    logic ld_prio, idle, st_grant, ld_grant, ld_resp;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_next;
    end

    // a response always wins over a same-cycle flush; the flush then only suppresses writeback
    always_comb begin
        state_next = idle ? (st_grant ? ST_WAIT : ld_grant ? LD_WAIT : IDLE) :
                     dmem_resp ? IDLE :
                     (state == LD_WAIT && br_flush) ? LD_DROP : state;
    end

    // grant never looks at ld_valid on the store side, avoiding a loop through LQ can_issue
    always_comb begin
        idle = state == IDLE;
        st_grant = idle && st_valid && !ld_prio && !rst;
        ld_grant = idle && ld_valid && !st_grant && !br_flush && !rst;
        ld_resp = state == LD_WAIT && dmem_resp;
        store_selected = st_grant;
        store_selected_index = st_grant ? st_index : '0;
        lq_stall = !idle || st_grant;
        dmem_addr = {req_addr[31:2], 2'b00};
        dmem_wdata = req_wdata;
        dmem_rmask = (state == LD_WAIT || state == LD_DROP) ? load_rmask(req_funct3, req_addr[1:0]) : '0;
        dmem_wmask = state == ST_WAIT ? req_wmask : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_addr <= '0;
            req_wdata <= '0;
            req_wmask <= '0;
            req_funct3 <= '0;
            req_paddr <= '0;
            req_rob_idx <= '0;
        end else if (st_grant) begin
            req_addr <= st_addr;
            req_wmask <= st_wmask;
            req_wdata <= st_wdata;
        end else if (ld_grant) begin
            req_addr <= ld_addr;
            req_funct3 <= ld_funct3;
            req_paddr <= ld_rd_paddr;
            req_rob_idx <= ld_rob_idx;
        end
    end

    load_align u_align (
        .rdata(dmem_rdata),
        .off(req_addr[1:0]),
        .funct3(req_funct3),
        .data(aligned)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ld_wb_valid <= 1'b0;
            st_done <= 1'b0;
            ld_wb_data <= '0;
            ld_wb_paddr <= '0;
            ld_wb_rob_idx <= '0;
        end else begin
            ld_wb_valid <= ld_resp && !br_flush;
            st_done <= state == ST_WAIT && dmem_resp;
            if (ld_resp) begin
                ld_wb_data <= aligned;
                ld_wb_paddr <= req_paddr;
                ld_wb_rob_idx <= req_rob_idx;
            end
        end
    end

    // once ld_prio is set stores stay blocked, so the counter cannot run past the limit
    always_ff @(posedge clk) begin
        if (rst || br_flush || lq_empty || ld_grant) begin
            starve_cnt <= '0;
            ld_prio <= 1'b0;
        end else if (st_grant) begin
            starve_cnt <= starve_cnt + 1'b1;
            if (starve_cnt == CW'(STARVE_LIMIT - 1)) ld_prio <= 1'b1;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(idle && dmem_resp));
endmodule

// File: tb/tb_lsq_dmem_arbiter.sv
// tb_lsq_dmem_arbiter: scoreboard bench for the LSQ data-cache arbiter
module tb_lsq_dmem_arbiter;
    import rv32i_types::*;
    localparam int AW = $clog2(LSQ_DEPTH);

    logic clk = 1'b0;
    logic rst, br_flush, lq_empty, ld_valid, st_valid, dmem_resp;
    logic [31:0] ld_addr, st_addr, st_wdata, dmem_rdata;
    logic [2:0] ld_funct3;
    logic [PHYS_WIDTH-1:0] ld_rd_paddr, ld_wb_paddr;
    logic [ROB_IDX_WIDTH-1:0] ld_rob_idx, ld_wb_rob_idx;
    logic [AW-1:0] st_index, store_selected_index;
    logic [3:0] st_wmask, dmem_rmask, dmem_wmask;
    logic lq_stall, store_selected, ld_wb_valid, st_done;
    logic [31:0] dmem_addr, dmem_wdata, ld_wb_data;

    typedef struct {
        logic is_ld;
        logic [31:0] data;
        logic [PHYS_WIDTH-1:0] paddr;
        logic [ROB_IDX_WIDTH-1:0] rob;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsq_dmem_arbiter #(.DEPTH(LSQ_DEPTH), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst), .br_flush(br_flush), .lq_empty(lq_empty),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
        .ld_rd_paddr(ld_rd_paddr), .ld_rob_idx(ld_rob_idx),
        .st_valid(st_valid), .st_index(st_index), .st_addr(st_addr),
        .st_wmask(st_wmask), .st_wdata(st_wdata),
        .lq_stall(lq_stall), .store_selected(store_selected),
        .store_selected_index(store_selected_index),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata),
        .ld_wb_valid(ld_wb_valid), .ld_wb_paddr(ld_wb_paddr), .ld_wb_data(ld_wb_data),
        .ld_wb_rob_idx(ld_wb_rob_idx), .st_done(st_done)
    );

    function automatic logic [31:0] model_data(input logic [31:0] rd, input logic [1:0] o, input logic [2:0] f);
        logic [7:0] b;
        logic [15:0] h;
        b = rd[8*o +: 8];
        h = o[1] ? rd[31:16] : rd[15:0];
        case (f)
            3'b000: return {{24{b[7]}}, b};
            3'b100: return {24'h0, b};
            3'b001: return {{16{h[15]}}, h};
            3'b101: return {16'h0, h};
            default: return rd;
        endcase
    endfunction

    function automatic logic [3:0] model_mask(input logic [1:0] o, input logic [2:0] f);
        case (f)
            3'b000, 3'b100: return o == 2'd0 ? 4'b0001 : o == 2'd1 ? 4'b0010 : o == 2'd2 ? 4'b0100 : 4'b1000;
            3'b001, 3'b101: return o[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // writeback monitor: every completion must match the oldest scoreboard entry
    always @(negedge clk) begin
        if (!rst && (ld_wb_valid || st_done)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL spurious_completion ld_wb_valid=%0b st_done=%0b, none expected", ld_wb_valid, st_done);
            end else begin
                mon_e = exp_q.pop_front();
                if (ld_wb_valid !== mon_e.is_ld || st_done !== !mon_e.is_ld) begin
                    errors++;
                    $display("FAIL completion_kind ld_wb_valid=%0b st_done=%0b, expected load=%0b", ld_wb_valid, st_done, mon_e.is_ld);
                end else if (mon_e.is_ld && (ld_wb_data !== mon_e.data || ld_wb_paddr !== mon_e.paddr || ld_wb_rob_idx !== mon_e.rob)) begin
                    errors++;
                    $display("FAIL load_wb got data=%h paddr=%0d rob=%0d expected data=%h paddr=%0d rob=%0d",
                             ld_wb_data, ld_wb_paddr, ld_wb_rob_idx, mon_e.data, mon_e.paddr, mon_e.rob);
                end
            end
        end
    end

    task automatic idle_in();
        br_flush = 0; lq_empty = 1; ld_valid = 0; ld_addr = 0; ld_funct3 = 0;
        ld_rd_paddr = 0; ld_rob_idx = 0; st_valid = 0; st_index = 0; st_addr = 0;
        st_wmask = 0; st_wdata = 0; dmem_resp = 0; dmem_rdata = 0;
    endtask

    task automatic push(input logic is_ld, input logic [31:0] d, input logic [PHYS_WIDTH-1:0] p, input logic [ROB_IDX_WIDTH-1:0] r);
        exp_t e;
        e.is_ld = is_ld; e.data = d; e.paddr = p; e.rob = r;
        exp_q.push_back(e);
    endtask

    task automatic load_tail(input logic [31:0] a, input logic [3:0] em, input logic [31:0] rd);
        @(negedge clk);
        ld_valid = 0;
        #1;
        checks++;
        if (dmem_rmask !== em || dmem_addr !== {a[31:2], 2'b00} || dmem_wmask !== 4'b0 || lq_stall !== 1'b1) begin
            errors++;
            $display("FAIL load_request rmask=%b addr=%h wmask=%b stall=%b expected rmask=%b addr=%h wmask=0000 stall=1",
                     dmem_rmask, dmem_addr, dmem_wmask, lq_stall, em, {a[31:2], 2'b00});
        end
        @(negedge clk);
        checks++;
        if (dmem_rmask !== em) begin
            errors++;
            $display("FAIL load_hold rmask=%b expected %b", dmem_rmask, em);
        end
        dmem_resp = 1; dmem_rdata = rd;
        @(negedge clk);
        dmem_resp = 0; dmem_rdata = 0;
        checks++;
        if (dmem_rmask !== 4'b0) begin
            errors++;
            $display("FAIL load_release rmask=%b expected 0000", dmem_rmask);
        end
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] f, input logic [31:0] rd,
                           input logic [3:0] em, input logic [31:0] ed,
                           input logic [PHYS_WIDTH-1:0] p, input logic [ROB_IDX_WIDTH-1:0] r);
        @(negedge clk);
        ld_valid = 1; ld_addr = a; ld_funct3 = f; ld_rd_paddr = p; ld_rob_idx = r;
        #1;
        checks++;
        if (store_selected !== 1'b0 || lq_stall !== 1'b0) begin
            errors++;
            $display("FAIL load_grant store_selected=%b lq_stall=%b expected 0 0", store_selected, lq_stall);
        end
        push(1'b1, ed, p, r);
        load_tail(a, em, rd);
    endtask

    task automatic store_tail(input logic [31:0] a, input logic [3:0] wm, input logic [31:0] wd, input logic keep);
        @(negedge clk);
        st_valid = keep;
        #1;
        checks++;
        if (dmem_wmask !== wm || dmem_wdata !== wd || dmem_addr !== {a[31:2], 2'b00} || dmem_rmask !== 4'b0 || store_selected !== 1'b0) begin
            errors++;
            $display("FAIL store_request wmask=%b wdata=%h addr=%h rmask=%b sel=%b expected wmask=%b wdata=%h addr=%h rmask=0000 sel=0",
                     dmem_wmask, dmem_wdata, dmem_addr, dmem_rmask, store_selected, wm, wd, {a[31:2], 2'b00});
        end
        @(negedge clk);
        dmem_resp = 1;
        @(negedge clk);
        dmem_resp = 0;
        checks++;
        if (dmem_wmask !== 4'b0) begin
            errors++;
            $display("FAIL store_release wmask=%b expected 0000", dmem_wmask);
        end
    endtask

    task automatic check_store_grant(input logic exp_sel, input logic [AW-1:0] idx, input string tag);
        #1;
        checks++;
        if (store_selected !== exp_sel || (exp_sel && (store_selected_index !== idx || lq_stall !== 1'b1))) begin
            errors++;
            $display("FAIL %s store_selected=%b index=%0d lq_stall=%b expected sel=%b index=%0d", tag,
                     store_selected, store_selected_index, lq_stall, exp_sel, idx);
        end
    endtask

    task automatic test_reset();
        rst = 1;
        idle_in();
        repeat (3) @(negedge clk);
        checks++;
        if ({lq_stall, store_selected, store_selected_index, dmem_rmask, dmem_wmask, dmem_addr, dmem_wdata,
             ld_wb_valid, ld_wb_paddr, ld_wb_data, ld_wb_rob_idx, st_done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs stall=%b sel=%b rmask=%b wmask=%b addr=%h wb=%b st_done=%b expected all zero",
                     lq_stall, store_selected, dmem_rmask, dmem_wmask, dmem_addr, ld_wb_valid, st_done);
        end
        st_valid = 1;
        check_store_grant(1'b0, '0, "reset_no_grant");
        st_valid = 0;
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_single_load();
        do_load(32'h1000_0008, LW, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF, 6'd5, 5'd3);
    endtask

    task automatic test_align();
        do_load(32'h1000_0013, LB, 32'h8011_2233, 4'b1000, 32'hFFFF_FF80, 6'd7, 5'd1);
        do_load(32'h1000_0022, LHU, 32'h8011_2233, 4'b1100, 32'h0000_8011, 6'd9, 5'd2);
        do_load(32'h1000_0021, LBU, 32'h8011_2233, 4'b0010, 32'h0000_0022, 6'd10, 5'd4);
        do_load(32'h1000_0020, LH, 32'h8011_F233, 4'b0011, 32'hFFFF_F233, 6'd11, 5'd6);
    endtask

    task automatic test_random_loads();
        logic [2:0] fs [5];
        fs = '{LB, LH, LW, LBU, LHU};
        for (int i = 0; i < 8; i++) begin
            logic [2:0] f;
            logic [1:0] o;
            logic [31:0] a, rd;
            f = fs[$urandom_range(0, 4)];
            o = f[1] ? 2'd0 : f[0] ? 2'($urandom_range(0, 1) * 2) : 2'($urandom_range(0, 3));
            a = {$urandom, 2'b00} | 32'(o);
            rd = $urandom;
            do_load(a, f, rd, model_mask(o, f), model_data(rd, o, f), 6'($urandom), 5'($urandom));
        end
    endtask

    task automatic test_store_vs_load();
        @(negedge clk);
        lq_empty = 0;
        ld_valid = 1; ld_addr = 32'h3000_0004; ld_funct3 = LW; ld_rd_paddr = 6'd12; ld_rob_idx = 5'd9;
        st_valid = 1; st_index = 3'd5; st_addr = 32'h2000_0004; st_wmask = 4'b0110; st_wdata = 32'h00AB_CD00;
        check_store_grant(1'b1, 3'd5, "store_over_load");
        push(1'b0, '0, '0, '0);
        store_tail(32'h2000_0004, 4'b0110, 32'h00AB_CD00, 1'b0);
        #1;
        checks++;
        if (lq_stall !== 1'b0 || store_selected !== 1'b0) begin
            errors++;
            $display("FAIL load_after_store lq_stall=%b sel=%b expected 0 0", lq_stall, store_selected);
        end
        push(1'b1, 32'h1234_5678, 6'd12, 5'd9);
        load_tail(32'h3000_0004, 4'b1111, 32'h1234_5678);
        idle_in();
    endtask

    task automatic test_starvation();
        @(negedge clk);
        lq_empty = 0; ld_valid = 0;
        for (int i = 0; i < 4; i++) begin
            st_valid = 1; st_index = 3'(i); st_addr = 32'h4000_0000 + 32'(i * 4);
            st_wmask = 4'b1111; st_wdata = $urandom;
            check_store_grant(1'b1, 3'(i), "starve_store");
            push(1'b0, '0, '0, '0);
            store_tail(st_addr, 4'b1111, st_wdata, 1'b1);
        end
        check_store_grant(1'b0, '0, "ld_prio_block");
        @(negedge clk);
        check_store_grant(1'b0, '0, "ld_prio_hold");
        ld_valid = 1; ld_addr = 32'h5000_0000; ld_funct3 = LW; ld_rd_paddr = 6'd20; ld_rob_idx = 5'd17;
        #1;
        checks++;
        if (store_selected !== 1'b0 || lq_stall !== 1'b0) begin
            errors++;
            $display("FAIL ld_prio_grant sel=%b stall=%b expected 0 0", store_selected, lq_stall);
        end
        push(1'b1, 32'hCAFE_0001, 6'd20, 5'd17);
        load_tail(32'h5000_0000, 4'b1111, 32'hCAFE_0001);
        st_index = 3'd6;
        check_store_grant(1'b1, 3'd6, "starve_cleared");
        push(1'b0, '0, '0, '0);
        store_tail(st_addr, 4'b1111, st_wdata, 1'b0);
        idle_in();
    endtask

    task automatic test_flush();
        @(negedge clk);
        ld_valid = 1; ld_addr = 32'h6000_0001; ld_funct3 = LB; ld_rd_paddr = 6'd30; ld_rob_idx = 5'd20;
        @(negedge clk);
        ld_valid = 0;
        br_flush = 1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (dmem_rmask !== 4'b0010 || dmem_addr !== 32'h6000_0000) begin
                errors++;
                $display("FAIL flush_hold cycle=%0d rmask=%b addr=%h expected 0010 60000000", c, dmem_rmask, dmem_addr);
            end
            @(negedge clk);
            br_flush = c == 0;
        end
        dmem_resp = 1; dmem_rdata = 32'h0000_FF00;
        @(negedge clk);
        dmem_resp = 0;
        checks++;
        if (ld_wb_valid !== 1'b0 || dmem_rmask !== 4'b0) begin
            errors++;
            $display("FAIL flush_drop wb_valid=%b rmask=%b expected 0 0000", ld_wb_valid, dmem_rmask);
        end
        do_load(32'h6000_0004, LW, 32'hA5A5_5A5A, 4'b1111, 32'hA5A5_5A5A, 6'd31, 5'd21);
    endtask

    task automatic test_flush_resp();
        @(negedge clk);
        ld_valid = 1; ld_addr = 32'h7000_0000; ld_funct3 = LW; ld_rd_paddr = 6'd2; ld_rob_idx = 5'd2;
        @(negedge clk);
        ld_valid = 0;
        @(negedge clk);
        dmem_resp = 1; br_flush = 1;
        @(negedge clk);
        dmem_resp = 0; br_flush = 0;
        checks++;
        if (ld_wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_resp wb_valid=%b expected 0", ld_wb_valid);
        end
    endtask

    task automatic test_store_flush();
        @(negedge clk);
        st_valid = 1; st_index = 3'd2; st_addr = 32'h8000_0010; st_wmask = 4'b0001; st_wdata = 32'h0000_0077;
        br_flush = 1;
        check_store_grant(1'b1, 3'd2, "store_with_flush");
        push(1'b0, '0, '0, '0);
        store_tail(32'h8000_0010, 4'b0001, 32'h0000_0077, 1'b0);
        br_flush = 0;
        idle_in();
    endtask

    task automatic test_rst_mid_store();
        @(negedge clk);
        st_valid = 1; st_index = 3'd1; st_addr = 32'h9000_0000; st_wmask = 4'b1100; st_wdata = 32'hBEEF_0000;
        check_store_grant(1'b1, 3'd1, "store_before_rst");
        @(negedge clk);
        st_valid = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        #1;
        checks++;
        if (dmem_wmask !== 4'b0 || dmem_rmask !== 4'b0 || lq_stall !== 1'b0 || st_done !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_store wmask=%b rmask=%b stall=%b st_done=%b expected all 0", dmem_wmask, dmem_rmask, lq_stall, st_done);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_align();
        test_random_loads();
        test_store_vs_load();
        test_starvation();
        test_flush();
        test_flush_resp();
        test_store_flush();
        test_rst_mid_store();
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain pending=%0d expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end
endmodule
